// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions used by both the display decoder and the
// capture side, so that both ends read from one glyph table.
//   seg7_t       : active-low segment vector, index 0 = g ... index 6 = a
//   SEG7_0..F    : legal hex glyphs
//   SEG7_DASH    : '-' glyph (never a legal hex digit)
//   SEG7_BLANK   : all segments off
//   filt_state_e : stability filter states
package seg7_pkg;

  typedef logic [0:6] seg7_t;

  localparam seg7_t SEG7_0     = 7'b1000000;
  localparam seg7_t SEG7_1     = 7'b1111001;
  localparam seg7_t SEG7_2     = 7'b0100100;
  localparam seg7_t SEG7_3     = 7'b0110000;
  localparam seg7_t SEG7_4     = 7'b0011001;
  localparam seg7_t SEG7_5     = 7'b0010010;
  localparam seg7_t SEG7_6     = 7'b0000010;
  localparam seg7_t SEG7_7     = 7'b1011000;
  localparam seg7_t SEG7_8     = 7'b0000000;
  localparam seg7_t SEG7_9     = 7'b0010000;
  localparam seg7_t SEG7_A     = 7'b0001000;
  localparam seg7_t SEG7_B     = 7'b0000011;
  localparam seg7_t SEG7_C     = 7'b1000110;
  localparam seg7_t SEG7_D     = 7'b0100001;
  localparam seg7_t SEG7_E     = 7'b0000110;
  localparam seg7_t SEG7_F     = 7'b0001110;
  localparam seg7_t SEG7_DASH  = 7'b0111111;
  localparam seg7_t SEG7_BLANK = 7'b1111111;

  typedef enum logic {
    StTrack,
    StSettled
  } filt_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Inverse of the segment encoding: maps an active-low glyph back to its nibble.
// Ports:
//   seg_i    : active-low segment pattern (seg7_t)
//   err_o    : 1 when seg_i is not one of the 16 hex glyphs
//   nibble_o : recovered nibble, 0 when err_o is set
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  seg7_t      seg_i,
  output logic       err_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    err_o    = 1'b0;
    nibble_o = 4'h0;
    case (seg_i)
      SEG7_0:  nibble_o = 4'h0;
      SEG7_1:  nibble_o = 4'h1;
      SEG7_2:  nibble_o = 4'h2;
      SEG7_3:  nibble_o = 4'h3;
      SEG7_4:  nibble_o = 4'h4;
      SEG7_5:  nibble_o = 4'h5;
      SEG7_6:  nibble_o = 4'h6;
      SEG7_7:  nibble_o = 4'h7;
      SEG7_8:  nibble_o = 4'h8;
      SEG7_9:  nibble_o = 4'h9;
      SEG7_A:  nibble_o = 4'hA;
      SEG7_B:  nibble_o = 4'hB;
      SEG7_C:  nibble_o = 4'hC;
      SEG7_D:  nibble_o = 4'hD;
      SEG7_E:  nibble_o = 4'hE;
      SEG7_F:  nibble_o = 4'hF;
      default: err_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Receive side of a multiplexed 7-segment interface. Debounces {an, seg},
// decodes each settled digit into a slot, and hands a complete frame to the
// consumer over valid/ready.
// Build option: define SEG7_CAPTURE_SYNC_EN to put a 2-flop synchronizer on
// seg_in/an_in (asynchronous pins); otherwise pins are sampled directly.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   seg_in      : active-low segments, [0]=g ... [6]=a
//   an_in       : active-low digit select, one-hot-low expected
//   frame_data  : recovered nibbles, digit i at [4i+3:4i]
//   frame_err   : per-digit illegal-glyph flags
//   frame_valid : frame_data/frame_err hold a complete frame
//   frame_ready : consumer accepts the frame when high with frame_valid
//   overflow    : sticky, a completed frame was dropped
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [0:6]          seg_in,
  input  logic [DIGITS-1:0]   an_in,
  output logic [4*DIGITS-1:0] frame_data,
  output logic [DIGITS-1:0]   frame_err,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                overflow
);

  localparam int unsigned CntW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  seg7_t             seg_s;
  logic [DIGITS-1:0] an_s;

`ifdef SEG7_CAPTURE_SYNC_EN
  seg7_t             seg_m_q, seg_s_q;
  logic [DIGITS-1:0] an_m_q, an_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m_q <= '1;
      seg_s_q <= '1;
      an_m_q  <= '1;
      an_s_q  <= '1;
    end else begin
      seg_m_q <= seg_in;
      seg_s_q <= seg_m_q;
      an_m_q  <= an_in;
      an_s_q  <= an_m_q;
    end
  end

  assign seg_s = seg_s_q;
  assign an_s  = an_s_q;
`else
  assign seg_s = seg_in;
  assign an_s  = an_in;
`endif

  // Stability filter
  filt_state_e       state_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  seg7_t             seg_prev_q;
  logic [DIGITS-1:0] an_prev_q;
  logic              same, in_track, settle;

  assign same     = (seg_s == seg_prev_q) && (an_s == an_prev_q);
  // A change always restarts tracking, even from SETTLED.
  assign in_track = !same || (state_q == StTrack);
  assign cnt_d    = same ? cnt_q + 1'b1 : '0;
  assign settle   = in_track && (cnt_d == CntMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StTrack;
      cnt_q      <= '0;
      seg_prev_q <= '1;
      an_prev_q  <= '1;
    end else begin
      seg_prev_q <= seg_s;
      an_prev_q  <= an_s;
      if (in_track) begin
        cnt_q   <= cnt_d;
        state_q <= settle ? StSettled : StTrack;
      end
    end
  end

  // Capture into slots
  logic              dec_err;
  logic [3:0]        dec_nib;
  logic [DIGITS-1:0] an_low;
  logic              one_low, capture, frame_done;

  seg7_pattern_decode u_decode (
    .seg_i    (seg_s),
    .err_o    (dec_err),
    .nibble_o (dec_nib)
  );

  assign an_low  = ~an_s;
  assign one_low = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
  assign capture = settle && one_low;

  logic [4*DIGITS-1:0] slot_data_q, slot_data_d;
  logic [DIGITS-1:0]   slot_err_q, slot_err_d;
  logic [DIGITS-1:0]   seen_q, seen_d;

  assign frame_done = &seen_q;

  always_comb begin
    slot_data_d = slot_data_q;
    slot_err_d  = slot_err_q;
    // Completion clears seen; a capture in the same cycle starts the next frame.
    seen_d      = frame_done ? '0 : seen_q;
    if (capture) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (an_low[i]) begin
          slot_data_d[4*i +: 4] = dec_nib;
          slot_err_d[i]         = dec_err;
          seen_d[i]             = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_data_q <= '0;
      slot_err_q  <= '0;
      seen_q      <= '0;
    end else begin
      slot_data_q <= slot_data_d;
      slot_err_q  <= slot_err_d;
      seen_q      <= seen_d;
    end
  end

  // Frame register and handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_data  <= '0;
      frame_err   <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
    end else if (frame_done) begin
      if (!frame_valid || frame_ready) begin
        frame_data  <= slot_data_q;
        frame_err   <= slot_err_q;
        frame_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;
  import seg7_pkg::*;

  localparam int unsigned Digits = 4;
  localparam int unsigned Stable = 4;
`ifdef SEG7_CAPTURE_SYNC_EN
  localparam int unsigned SyncLat = 2;
`else
  localparam int unsigned SyncLat = 0;
`endif
  // Edges from the first sample of the last digit until frame_valid is seen.
  localparam int unsigned Lat  = Stable + 1 + SyncLat;
  localparam int unsigned Hold = 8 + SyncLat;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [0:6]          seg_in;
  logic [Digits-1:0]   an_in;
  logic [4*Digits-1:0] frame_data;
  logic [Digits-1:0]   frame_err;
  logic                frame_valid;
  logic                frame_ready;
  logic                overflow;

  always #5 clk = ~clk;

  seg7_capture #(
    .DIGITS        (Digits),
    .STABLE_CYCLES (Stable)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overflow    (overflow)
  );

  // Record every accepted frame.
  int          acc_cnt  = 0;
  logic [15:0] acc_data = '0;
  logic [3:0]  acc_err  = '0;

  always @(posedge clk) begin
    if (rst_n && frame_valid && frame_ready) begin
      acc_cnt  <= acc_cnt + 1;
      acc_data <= frame_data;
      acc_err  <= frame_err;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [3:0] dig(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i);
  endfunction

  task automatic drive(input logic [3:0] an, input seg7_t seg, input int unsigned n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input seg7_t s0, input seg7_t s1, input seg7_t s2, input seg7_t s3);
    drive(dig(0), s0, Hold);
    drive(dig(1), s1, Hold);
    drive(dig(2), s2, Hold);
    drive(dig(3), s3, Hold);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n       = 1'b0;
    an_in       = '1;
    seg_in      = SEG7_BLANK;
    frame_ready = 1'b1;
    #12;
    check("rst_data", frame_data, 0);
    check("rst_err", frame_err, 0);
    check("rst_valid", frame_valid, 0);
    check("rst_ovf", overflow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic frame 1,2,3,4 with latency measurement on the last digit
    drive(dig(0), SEG7_1, Hold);
    drive(dig(1), SEG7_2, Hold);
    drive(dig(2), SEG7_3, Hold);
    an_in  = dig(3);
    seg_in = SEG7_4;
    lat    = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (frame_valid && lat == 0) lat = k;
    end
    check("latency", lat, Lat);
    check("t1_acc_cnt", acc_cnt, 1);
    check("t1_data", acc_data, 16'h4321);
    check("t1_err", acc_err, 4'b0000);
    check("t1_valid_low", frame_valid, 0);
    check("t1_ovf", overflow, 0);

    // Dash on digit 2
    scan(SEG7_5, SEG7_6, SEG7_DASH, SEG7_F);
    check("t2_acc_cnt", acc_cnt, 2);
    check("t2_data", acc_data, 16'hF065);
    check("t2_err", acc_err, 4'b0100);

    // Glitching digit 1 never settles
    drive(dig(0), SEG7_A, Hold);
    drive(dig(2), SEG7_B, Hold);
    drive(dig(3), SEG7_C, Hold);
    for (int r = 0; r < 8; r++) begin
      drive(dig(1), (r % 3 == 0) ? SEG7_1 : (r % 3 == 1) ? SEG7_2 : SEG7_3, 3);
    end
    check("t3_glitch_cnt", acc_cnt, 2);
    check("t3_glitch_valid", frame_valid, 0);
    drive(dig(1), SEG7_7, Hold);
    check("t3_acc_cnt", acc_cnt, 3);
    check("t3_data", acc_data, 16'hCB7A);
    check("t3_err", acc_err, 4'b0000);

    // Recapture overwrites; two-low select is ignored
    drive(dig(0), SEG7_1, Hold);
    drive(dig(1), SEG7_2, Hold);
    drive(dig(0), SEG7_E, Hold);
    drive(dig(2), SEG7_3, Hold);
    drive(4'b1100, SEG7_8, 10);
    check("t4_multi_cnt", acc_cnt, 3);
    check("t4_multi_valid", frame_valid, 0);
    drive(dig(3), SEG7_9, Hold);
    check("t4_acc_cnt", acc_cnt, 4);
    check("t4_data", acc_data, 16'h932E);

    // Back-pressure: second frame dropped
    frame_ready = 1'b0;
    scan(SEG7_1, SEG7_2, SEG7_3, SEG7_4);
    check("t5_valid", frame_valid, 1);
    check("t5_data", frame_data, 16'h4321);
    check("t5_ovf0", overflow, 0);
    scan(SEG7_8, SEG7_8, SEG7_8, SEG7_8);
    check("t5_ovf1", overflow, 1);
    check("t5_held_data", frame_data, 16'h4321);
    check("t5_held_valid", frame_valid, 1);
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    check("t5_acc_cnt", acc_cnt, 5);
    check("t5_acc_data", acc_data, 16'h4321);
    check("t5_valid_low", frame_valid, 0);
    check("t5_ovf_sticky", overflow, 1);

    // Reset mid-frame
    drive(dig(0), SEG7_5, Hold);
    drive(dig(1), SEG7_6, Hold);
    rst_n = 1'b0;
    #2;
    check("t7_rst_data", frame_data, 0);
    check("t7_rst_valid", frame_valid, 0);
    check("t7_rst_ovf", overflow, 0);
    an_in  = '1;
    seg_in = SEG7_BLANK;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(dig(2), SEG7_3, Hold);
    drive(dig(3), SEG7_4, Hold);
    check("t7_partial_valid", frame_valid, 0);
    drive(dig(0), SEG7_1, Hold);
    drive(dig(1), SEG7_2, Hold);
    check("t7_valid", frame_valid, 1);
    check("t7_data", frame_data, 16'h4321);
    check("t7_err", frame_err, 4'b0000);

    // Ready coincides with the load of the next frame
    drive(dig(0), SEG7_D, Hold);
    drive(dig(1), SEG7_E, Hold);
    drive(dig(2), SEG7_F, Hold);
    an_in  = dig(3);
    seg_in = SEG7_0;
    repeat (Lat - 1) @(posedge clk);
    #1;
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    check("t6_valid", frame_valid, 1);
    check("t6_data", frame_data, 16'h0FED);
    check("t6_ovf", overflow, 0);
    check("t6_acc_cnt", acc_cnt, 6);
    check("t6_acc_data", acc_data, 16'h4321);
    repeat (3) @(posedge clk);
    #1;
    check("t6_hold_valid", frame_valid, 1);
    check("t6_hold_data", frame_data, 16'h0FED);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
